// File: rtl/aes_shiftrows_stream.sv
// aes_shiftrows_stream: beat-streamed AES ShiftRows/InvShiftRows with optional ping-pong state banks
module aes_shiftrows_stream #(
    parameter int BEAT_BYTES = 1,
    parameter int DOUBLE_BUF = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    flush,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*BEAT_BYTES-1:0] s_data,
    input  logic                    s_inv,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*BEAT_BYTES-1:0] m_data,
    output logic                    m_last,
    output logic                    busy
);
    localparam int W = 8 * BEAT_BYTES;
    localparam int BEATS = 16 / BEAT_BYTES;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic TOG = DOUBLE_BUF != 0;
    logic [127:0] bank [2];
    logic [127:0] cur, perm;
    logic [1:0] inv, full;
    logic wp, rp, s_fire, m_fire;
    logic [CW-1:0] icnt, ocnt;
    assign s_ready = !full[wp];
    assign m_valid = full[rp];
    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;
    assign m_last = m_valid && ocnt == LAST;
    assign busy = |full || icnt != '0;
    assign cur = bank[rp];
    assign m_data = m_valid ? perm[127-W*int'(ocnt) -: W] : '0;
    always_comb begin
        perm = '0;
        for (int k = 0; k < 16; k++)
            perm[127-8*k -: 8] = inv[rp] ? cur[127-8*(k%4+4*((k/4+4-k%4)%4)) -: 8]
                                         : cur[127-8*(k%4+4*((k/4+k%4)%4)) -: 8];
    end
    always_ff @(posedge HCLK) begin
        if (!HRESETn || flush) begin
            full <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            icnt <= '0;
            ocnt <= '0;
        end else begin
            if (s_fire) begin
                icnt <= icnt == LAST ? '0 : icnt + 1'b1;
                if (icnt == LAST) begin
                    full[wp] <= 1'b1;
                    wp       <= wp ^ TOG;
                end
            end
            if (m_fire) begin
                ocnt <= ocnt == LAST ? '0 : ocnt + 1'b1;
                if (ocnt == LAST) begin
                    full[rp] <= 1'b0;
                    rp       <= rp ^ TOG;
                end
            end
        end
    end
    always_ff @(posedge HCLK) begin
        if (s_fire) begin
            bank[wp][127-W*int'(icnt) -: W] <= s_data;
            if (icnt == '0) inv[wp] <= s_inv;
        end
    end
endmodule
